phyretrain_rx_responder: RTL and testbench

Parametrised receive-side PHYRETRAIN responder for the LTSM. It waits for the partner's PHYRETRAIN start request on the sideband and resolves the MBTRAIN re-entry state from the local and partner retrain encodings using a configurable state map. It then issues the start response through the shared sideband wrapper, yielding to the TX side while it transmits. Compared with the fixed 3-encoding responder, it adds a generic encoding width, encoding legality checking, a response-deferral flag and a watchdog timeout.

---
 rtl/phyretrain_rx_responder.sv | 189 ++++++++++++++++++
 tb/tb_phyretrain_rx_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/phyretrain_rx_responder.sv
// phyretrain_rx_responder
//   Receive-side PHYRETRAIN responder for the LTSM. Waits for the partner's
//   PHYRETRAIN start request, resolves the MBTRAIN re-entry state from the
//   local and partner one-hot retrain encodings through STATE_MAP, then
//   drives the start response into the shared sideband wrapper. A watchdog
//   aborts into TIMEOUT if the exchange stalls.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_en                  block enable; low returns to IDLE
//   i_clear_resolved      clears o_resolved_state (wins over capture)
//   i_local_enc/partner   one-hot retrain encodings
//   i_rx_msg_valid/i_decoded_msg   decoded partner message
//   i_sb_busy/i_sb_busy_fall       sideband wrapper status
//   i_tx_valid            TX responder owns the wrapper; we defer
//   o_encoded_msg/o_valid response to the wrapper
//   o_end, o_timeout      completion / watchdog levels
//   o_resolved_state, o_illegal_enc   resolution result
module phyretrain_rx_responder #(
  parameter int SB_MSG_WIDTH   = 4,
  parameter int ENC_WIDTH      = 3,
  parameter int STATE_WIDTH    = 2,
  parameter logic [ENC_WIDTH*STATE_WIDTH-1:0] STATE_MAP = {2'h2, 2'h3, 2'h1},
  parameter int REQ_MSG        = 1,
  parameter int RESP_MSG       = 2,
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic                    i_clear_resolved,
  input  logic [ENC_WIDTH-1:0]    i_local_enc,
  input  logic [ENC_WIDTH-1:0]    i_partner_enc,
  input  logic                    i_rx_msg_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_decoded_msg,
  input  logic                    i_sb_busy,
  input  logic                    i_sb_busy_fall,
  input  logic                    i_tx_valid,
  output logic [SB_MSG_WIDTH-1:0] o_encoded_msg,
  output logic                    o_valid,
  output logic                    o_end,
  output logic [STATE_WIDTH-1:0]  o_resolved_state,
  output logic                    o_illegal_enc,
  output logic                    o_timeout
);

  // Width must stay >= 1 even when the watchdog is disabled.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_REQ, S_SEND_RESP, S_DONE, S_TIMEOUT
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
  logic                    valid_q, valid_d;
  logic                    end_q, end_d;
  logic [STATE_WIDTH-1:0]  res_q, res_d;
  logic                    illegal_q, illegal_d;
  logic                    timeout_q, timeout_d;

  logic                    in_wd_state, wd_hit, accept, legal;
  logic [STATE_WIDTH-1:0]  map_loc, map_par;

  // Looks up the state code for a one-hot encoding (caller checks legality).
  function automatic logic [STATE_WIDTH-1:0] map_state(input logic [ENC_WIDTH-1:0] enc);
    logic [STATE_WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < ENC_WIDTH; k++)
      if (enc[k]) r = STATE_MAP[k*STATE_WIDTH +: STATE_WIDTH];
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    msg_d     = msg_q;
    valid_d   = valid_q;
    end_d     = end_q;
    res_d     = res_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    in_wd_state = (state_q == S_WAIT_REQ) || (state_q == S_SEND_RESP);
    wd_hit  = (TIMEOUT_CYCLES != 0) && in_wd_state && (cnt_q == CNT_LAST);
    // The watchdog wins over a request arriving in its final cycle.
    accept  = (state_q == S_WAIT_REQ) && i_rx_msg_valid && !wd_hit &&
              (i_decoded_msg == SB_MSG_WIDTH'(REQ_MSG));
    legal   = $onehot(i_local_enc) && $onehot(i_partner_enc);
    map_loc = map_state(i_local_enc);
    map_par = map_state(i_partner_enc);

    if (!i_en) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      pending_d = 1'b0;
      msg_d     = '0;
      valid_d   = 1'b0;
      end_d     = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_REQ;
          cnt_d   = '0;
        end
        S_WAIT_REQ: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (accept) begin
            state_d   = S_SEND_RESP;
            cnt_d     = '0;
            msg_d     = SB_MSG_WIDTH'(RESP_MSG);
            pending_d = 1'b1;
            if (legal) begin
              res_d     = (map_loc > map_par) ? map_loc : map_par;
              illegal_d = 1'b0;
            end else begin
              res_d     = '0;
              illegal_d = 1'b1;
            end
          end
        end
        S_SEND_RESP: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (i_sb_busy_fall && valid_q) begin
            state_d = S_DONE;
            end_d   = 1'b1;
          end
        end
        default: cnt_d = '0;  // DONE / TIMEOUT hold until i_en drops
      endcase

      // Wrapper handshake. pending_d already includes a same-cycle accept,
      // so a request on a free bus launches o_valid on the very next edge.
      if (valid_q && i_sb_busy_fall)
        valid_d = 1'b0;
      else if (pending_d && !valid_q && !i_sb_busy && !i_tx_valid) begin
        valid_d   = 1'b1;
        pending_d = 1'b0;
      end

      if (wd_hit) begin
        state_d   = S_TIMEOUT;
        cnt_d     = '0;
        timeout_d = 1'b1;
        valid_d   = 1'b0;
        pending_d = 1'b0;
        end_d     = end_q;
      end
    end

    if (i_clear_resolved) res_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      msg_q     <= '0;
      valid_q   <= 1'b0;
      end_q     <= 1'b0;
      res_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      msg_q     <= msg_d;
      valid_q   <= valid_d;
      end_q     <= end_d;
      res_q     <= res_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_encoded_msg    = msg_q;
  assign o_valid          = valid_q;
  assign o_end            = end_q;
  assign o_resolved_state = res_q;
  assign o_illegal_enc    = illegal_q;
  assign o_timeout        = timeout_q;

endmodule

// File: tb/tb_phyretrain_rx_responder.sv
module tb_phyretrain_rx_responder;
  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_en = 1'b0;
  logic       i_clear_resolved = 1'b0;
  logic [2:0] i_local_enc = '0;
  logic [2:0] i_partner_enc = '0;
  logic       i_rx_msg_valid = 1'b0;
  logic [3:0] i_decoded_msg = '0;
  logic       i_sb_busy = 1'b0;
  logic       i_sb_busy_fall = 1'b0;
  logic       i_tx_valid = 1'b0;
  logic [3:0] o_encoded_msg;
  logic       o_valid, o_end, o_illegal_enc, o_timeout;
  logic [1:0] o_resolved_state;

  int pass_cnt = 0;
  int total = 0;

  phyretrain_rx_responder #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_clear_resolved(i_clear_resolved),
    .i_local_enc(i_local_enc), .i_partner_enc(i_partner_enc),
    .i_rx_msg_valid(i_rx_msg_valid), .i_decoded_msg(i_decoded_msg),
    .i_sb_busy(i_sb_busy), .i_sb_busy_fall(i_sb_busy_fall),
    .i_tx_valid(i_tx_valid), .o_encoded_msg(o_encoded_msg),
    .o_valid(o_valid), .o_end(o_end), .o_resolved_state(o_resolved_state),
    .o_illegal_enc(o_illegal_enc), .o_timeout(o_timeout));

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Disable then enable: lands in WAIT_REQ with a fresh watchdog.
  task automatic restart();
    i_en = 1'b0; tick();
    i_en = 1'b1; tick();
  endtask

  task automatic send_req(input logic [2:0] l, input logic [2:0] p);
    i_local_enc = l; i_partner_enc = p;
    i_rx_msg_valid = 1'b1; i_decoded_msg = 4'd1;
    tick();
    i_rx_msg_valid = 1'b0; i_decoded_msg = 4'd0;
  endtask

  task automatic busy_fall();
    i_sb_busy_fall = 1'b1; tick(); i_sb_busy_fall = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if ({o_encoded_msg, o_valid, o_end, o_resolved_state, o_illegal_enc, o_timeout} !== 10'd0)
      $display("FAIL reset_outputs got %h exp 0", {o_encoded_msg, o_valid, o_end, o_resolved_state, o_illegal_enc, o_timeout}); else pass_cnt++;
    i_rst_n = 1'b1; tick();
    total++; if (o_valid !== 1'b0) $display("FAIL reset_idle_valid got %0b exp 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_basic();
    restart();
    // Non-request message is ignored.
    i_rx_msg_valid = 1'b1; i_decoded_msg = 4'd3; tick(); i_rx_msg_valid = 1'b0;
    total++; if (o_valid !== 1'b0) $display("FAIL basic_ignore_valid got %0b exp 0", o_valid); else pass_cnt++;
    send_req(3'b001, 3'b100);
    total++; if (o_valid !== 1'b1) $display("FAIL basic_valid got %0b exp 1", o_valid); else pass_cnt++;
    total++; if (o_encoded_msg !== 4'd2) $display("FAIL basic_msg got %0d exp 2", o_encoded_msg); else pass_cnt++;
    total++; if (o_resolved_state !== 2'd2) $display("FAIL basic_state got %0d exp 2", o_resolved_state); else pass_cnt++;
    i_sb_busy = 1'b1; tick(); tick();
    total++; if (o_end !== 1'b0) $display("FAIL basic_end_early got %0b exp 0", o_end); else pass_cnt++;
    i_sb_busy = 1'b0; busy_fall();
    total++; if (o_valid !== 1'b0) $display("FAIL basic_valid_clr got %0b exp 0", o_valid); else pass_cnt++;
    total++; if (o_end !== 1'b1) $display("FAIL basic_end got %0b exp 1", o_end); else pass_cnt++;
    // Repeat request in DONE must not recapture or relaunch.
    send_req(3'b010, 3'b010);
    total++; if (o_resolved_state !== 2'd2) $display("FAIL basic_no_recapture got %0d exp 2", o_resolved_state); else pass_cnt++;
    total++; if (o_valid !== 1'b0 || o_end !== 1'b1) $display("FAIL basic_done_hold got v=%0b e=%0b exp v=0 e=1", o_valid, o_end); else pass_cnt++;
  endtask

  task automatic test_resolution();
    int exp_tbl[3][3] = '{'{1, 3, 2}, '{3, 3, 3}, '{2, 3, 2}};
    logic [2:0] bad_l[2] = '{3'b000, 3'b011};
    logic [2:0] bad_p[2] = '{3'b010, 3'b001};
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        restart();
        send_req(3'(1 << i), 3'(1 << j));
        total++; if (o_resolved_state !== 2'(exp_tbl[i][j]) || o_illegal_enc !== 1'b0)
          $display("FAIL resolve_%0d_%0d got st=%0d ill=%0b exp st=%0d ill=0", i, j, o_resolved_state, o_illegal_enc, exp_tbl[i][j]);
        else pass_cnt++;
      end
    for (int k = 0; k < 2; k++) begin
      restart();
      send_req(3'b100, 3'b100);  // leave a nonzero state to overwrite
      restart();
      send_req(bad_l[k], bad_p[k]);
      total++; if (o_resolved_state !== 2'd0 || o_illegal_enc !== 1'b1)
        $display("FAIL resolve_illegal_%0d got st=%0d ill=%0b exp st=0 ill=1", k, o_resolved_state, o_illegal_enc);
      else pass_cnt++;
    end
    // Illegal partner side as well.
    restart();
    send_req(3'b010, 3'b110);
    total++; if (o_resolved_state !== 2'd0 || o_illegal_enc !== 1'b1)
      $display("FAIL resolve_illegal_partner got st=%0d ill=%0b exp st=0 ill=1", o_resolved_state, o_illegal_enc); else pass_cnt++;
  endtask

  // sel=0 defers with i_tx_valid, sel=1 with i_sb_busy.
  task automatic test_deferral(input int sel);
    logic ok;
    restart();
    if (sel == 0) i_tx_valid = 1'b1; else i_sb_busy = 1'b1;
    tick(); tick();
    send_req(3'b100, 3'b001);
    ok = (o_valid === 1'b0);
    tick(); ok &= (o_valid === 1'b0);
    tick(); ok &= (o_valid === 1'b0);
    total++; if (!ok) $display("FAIL defer%0d_held got %0b exp 0", sel, o_valid); else pass_cnt++;
    i_tx_valid = 1'b0; i_sb_busy = 1'b0;
    tick();
    total++; if (o_valid !== 1'b1 || o_encoded_msg !== 4'd2)
      $display("FAIL defer%0d_release got v=%0b m=%0d exp v=1 m=2", sel, o_valid, o_encoded_msg); else pass_cnt++;
  endtask

  task automatic test_timeout();
    restart();
    for (int c = 0; c < 15; c++) tick();
    total++; if (o_timeout !== 1'b0) $display("FAIL timeout_early got %0b exp 0", o_timeout); else pass_cnt++;
    tick();
    total++; if (o_timeout !== 1'b1) $display("FAIL timeout_fire got %0b exp 1", o_timeout); else pass_cnt++;
    send_req(3'b001, 3'b001);
    total++; if (o_timeout !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL timeout_hold got to=%0b v=%0b exp to=1 v=0", o_timeout, o_valid); else pass_cnt++;
    i_en = 1'b0; tick();
    total++; if (o_timeout !== 1'b0) $display("FAIL timeout_clear got %0b exp 0", o_timeout); else pass_cnt++;
  endtask

  task automatic test_abort();
    restart();
    send_req(3'b010, 3'b001);
    total++; if (o_valid !== 1'b1 || o_resolved_state !== 2'd3)
      $display("FAIL abort_setup got v=%0b st=%0d exp v=1 st=3", o_valid, o_resolved_state); else pass_cnt++;
    i_en = 1'b0; tick();
    total++; if (o_valid !== 1'b0 || o_encoded_msg !== 4'd0 || o_resolved_state !== 2'd3)
      $display("FAIL abort_drop got v=%0b m=%0d st=%0d exp v=0 m=0 st=3", o_valid, o_encoded_msg, o_resolved_state); else pass_cnt++;
    i_en = 1'b1; tick();
    send_req(3'b100, 3'b100);
    busy_fall();
    total++; if (o_end !== 1'b1 || o_resolved_state !== 2'd2)
      $display("FAIL abort_rerun got e=%0b st=%0d exp e=1 st=2", o_end, o_resolved_state); else pass_cnt++;
  endtask

  task automatic test_clear();
    restart();
    i_clear_resolved = 1'b1;
    send_req(3'b010, 3'b100);
    i_clear_resolved = 1'b0;
    total++; if (o_resolved_state !== 2'd0 || o_valid !== 1'b1)
      $display("FAIL clear_req got st=%0d v=%0b exp st=0 v=1", o_resolved_state, o_valid); else pass_cnt++;
    restart();
    send_req(3'b010, 3'b010);
    busy_fall();
    i_clear_resolved = 1'b1; tick(); i_clear_resolved = 1'b0;
    total++; if (o_resolved_state !== 2'd0 || o_end !== 1'b1)
      $display("FAIL clear_done got st=%0d e=%0b exp st=0 e=1", o_resolved_state, o_end); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    restart();
    send_req(3'b001, 3'b010);
    #2 i_rst_n = 1'b0;
    #1;
    total++; if (o_valid !== 1'b0 || o_resolved_state !== 2'd0)
      $display("FAIL async_reset got v=%0b st=%0d exp v=0 st=0", o_valid, o_resolved_state); else pass_cnt++;
    #1 i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_resolution();
    test_deferral(0);
    test_deferral(1);
    test_timeout();
    test_abort();
    test_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
